// File: rtl/scan_mux_n.sv
// Time-multiplexed N-channel scanner for a seven-segment digit/anode path.
// Each enabled channel is shown for PRESCALE cycles; disabled channels are skipped.
module scan_mux_n #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 4,
    parameter int PRESCALE = 100000,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     hold,
    output logic [DATA_W-1:0]        data_out,
    output logic [NUM_CH-1:0]        an_n,
    output logic [SEL_W-1:0]         sel,
    output logic                     slot_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [NUM_CH-1:0] an_n_q, an_n_d;
    logic              slot_tick_q, slot_tick_d;

    logic              advance;
    logic              found;
    logic [SEL_W-1:0]  next_ch;

    always_comb begin
        advance = (count_q == CNT_MAX) && !hold;
        count_d = count_q;
        if (advance) begin
            count_d = '0;
        end else if (!hold) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Search sel+1 .. sel+NUM_CH with an explicit modulo wrap, so a
    // non-power-of-two channel count can never yield an index past NUM_CH-1.
    always_comb begin
        int cand;
        cand    = 0;
        found   = 1'b0;
        next_ch = sel_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = int'(sel_q) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!found && ch_en[SEL_W'(cand)]) begin
                found   = 1'b1;
                next_ch = SEL_W'(cand);
            end
        end
    end

    always_comb begin
        sel_d       = advance ? next_ch : sel_q;
        slot_tick_d = advance;
        data_out_d  = '0;
        an_n_d      = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == sel_d) begin
                data_out_d = data_in[k*DATA_W +: DATA_W];
                an_n_d[k]  = ~ch_en[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            sel_q       <= '0;
            data_out_q  <= '0;
            an_n_q      <= '1;
            slot_tick_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            an_n_q      <= an_n_d;
            slot_tick_q <= slot_tick_d;
        end
    end

    assign data_out  = data_out_q;
    assign an_n      = an_n_q;
    assign sel       = sel_q;
    assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Scoreboard bench for scan_mux_n: directed vectors push expected responses,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_scan_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: 4 channels, 4-cycle slots
    logic        reset_a = 1'b1;
    logic        hold_a = 1'b0;
    logic [15:0] data_in_a = 16'hDCBA;
    logic [3:0]  ch_en_a = 4'b1111;
    logic [3:0]  data_out_a;
    logic [3:0]  an_n_a;
    logic [1:0]  sel_a;
    logic        slot_tick_a;

    // Configuration B: 3 channels, advance every cycle
    logic        reset_b = 1'b1;
    logic        hold_b = 1'b0;
    logic [11:0] data_in_b = 12'hCBA;
    logic [2:0]  ch_en_b = 3'b111;
    logic [3:0]  data_out_b;
    logic [2:0]  an_n_b;
    logic [1:0]  sel_b;
    logic        slot_tick_b;

    scan_mux_n #(.NUM_CH(4), .DATA_W(4), .PRESCALE(4)) dut_a (
        .clk(clk), .reset(reset_a), .data_in(data_in_a), .ch_en(ch_en_a), .hold(hold_a),
        .data_out(data_out_a), .an_n(an_n_a), .sel(sel_a), .slot_tick(slot_tick_a)
    );

    scan_mux_n #(.NUM_CH(3), .DATA_W(4), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(reset_b), .data_in(data_in_b), .ch_en(ch_en_b), .hold(hold_b),
        .data_out(data_out_b), .an_n(an_n_b), .sel(sel_b), .slot_tick(slot_tick_b)
    );

    typedef struct {
        int         dut;
        int         cyc;
        logic [3:0] sel;
        logic [3:0] an;
        logic [3:0] data;
        logic       tick;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand tables for the all-enabled four-channel scan of 16'hDCBA
    function automatic logic [3:0] an_of(input int s);
        case (s)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] dat_of(input int s);
        case (s)
            0:       return 4'hA;
            1:       return 4'hB;
            2:       return 4'hC;
            default: return 4'hD;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic applyStimulus(input int dut, input logic rst, input logic hld,
                                 input logic [15:0] din, input logic [3:0] en,
                                 input int e_sel, input logic [3:0] e_an,
                                 input logic [3:0] e_data, input logic e_tick,
                                 input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (dut == 0) begin
            reset_a   = rst;
            hold_a    = hld;
            data_in_a = din;
            ch_en_a   = en;
        end else begin
            reset_b   = rst;
            hold_b    = hld;
            data_in_b = din[11:0];
            ch_en_b   = en[2:0];
        end
        e.dut  = dut;
        e.cyc  = cyc + 1;
        e.sel  = 4'(e_sel);
        e.an   = e_an;
        e.data = e_data;
        e.tick = e_tick;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: pops every expectation whose target edge has passed
    task automatic checkOutput();
        exp_t       e;
        logic [3:0] act_sel, act_an, act_data;
        logic       act_tick;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                if (e.dut == 0) begin
                    act_sel  = {2'b00, sel_a};
                    act_an   = an_n_a;
                    act_data = data_out_a;
                    act_tick = slot_tick_a;
                end else begin
                    act_sel  = {2'b00, sel_b};
                    act_an   = {1'b0, an_n_b};
                    act_data = data_out_b;
                    act_tick = slot_tick_b;
                end
                total++;
                if (e.cyc != cyc || act_sel !== e.sel || act_an !== e.an ||
                    act_data !== e.data || act_tick !== e.tick) begin
                    bad++;
                    $display("[TB] FAIL %s cyc=%0d: got sel=%0d an_n=%b data=%h tick=%b, want sel=%0d an_n=%b data=%h tick=%b",
                             e.name, cyc, act_sel, act_an, act_data, act_tick,
                             e.sel, e.an, e.data, e.tick);
                end
            end
        end
    endtask

    initial checkOutput();

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;

        applyStimulus(1, 1, 0, 16'h0CBA, 4'b0111, 0, 4'b0111, 4'h0, 0, "b_reset");
        for (int i = 0; i < 2; i++)
            applyStimulus(0, 1, 0, 16'hDCBA, 4'b1111, 0, 4'b1111, 4'h0, 0, "a_reset");

        // All channels enabled: 0,1,2,3,0 with four cycles per slot
        for (int j = 1; j <= 20; j++) begin
            s = (j / 4) % 4;
            applyStimulus(0, 0, 0, 16'hDCBA, 4'b1111, s, an_of(s), dat_of(s), (j % 4) == 0, "scan_all");
        end

        // Only channels 1 and 3 enabled
        for (int k = 1; k <= 16; k++) begin
            s = ((k / 4) % 2 == 0) ? 1 : 3;
            applyStimulus(0, 0, 0, 16'hDCBA, 4'b1010, s, an_of(s), dat_of(s), (k % 4) == 0, "scan_1010");
        end

        // Nothing enabled: blank and frozen, but slots still tick
        for (int k = 1; k <= 8; k++)
            applyStimulus(0, 0, 0, 16'hDCBA, 4'b0000, 1, 4'b1111, 4'hB, (k % 4) == 0, "all_off");

        // Enabling channel 2 alone takes effect at the next slot boundary
        for (int k = 1; k <= 8; k++) begin
            s = (k < 4) ? 1 : 2;
            applyStimulus(0, 0, 0, 16'hDCBA, 4'b0100, s, (k < 4) ? 4'b1111 : 4'b1011,
                          dat_of(s), (k % 4) == 0, "only_ch2");
        end

        // Walk back to channel 1, one cycle into its slot
        for (int k = 1; k <= 13; k++) begin
            s = (k < 4) ? 2 : (k < 8) ? 3 : (k < 12) ? 0 : 1;
            applyStimulus(0, 0, 0, 16'hDCBA, 4'b1111, s, an_of(s), dat_of(s), (k % 4) == 0, "pre_hold");
        end

        // Hold freezes the scan but data still passes through in one cycle
        for (int h = 1; h <= 10; h++)
            applyStimulus(0, 0, 1, (h >= 5) ? 16'hDC7A : 16'hDCBA, 4'b1111, 1, 4'b1101,
                          (h >= 5) ? 4'h7 : 4'hB, 0, "hold");

        // Released with count at 1: two more cycles on channel 1, then move on
        for (int r = 1; r <= 9; r++) begin
            s = (r < 3) ? 1 : (r < 7) ? 2 : 3;
            applyStimulus(0, 0, 0, 16'hDC7A, 4'b1111, s, an_of(s),
                          (s == 1) ? 4'h7 : dat_of(s), (r == 3) || (r == 7), "release");
        end

        // Reset at sel=3, count=2, with hold also high: reset wins
        applyStimulus(0, 1, 1, 16'hDC7A, 4'b1111, 0, 4'b1111, 4'h0, 0, "reset_mid");
        for (int f = 1; f <= 5; f++) begin
            s = (f < 4) ? 0 : 1;
            applyStimulus(0, 0, 0, 16'hDC7A, 4'b1111, s, an_of(s),
                          (s == 0) ? 4'hA : 4'h7, f == 4, "after_reset");
        end

        // Three channels, one-cycle slots: 1,2,0,... with slot_tick stuck high
        for (int k = 1; k <= 7; k++) begin
            s = k % 3;
            applyStimulus(1, 0, 0, 16'h0CBA, 4'b0111, s,
                          (s == 0) ? 4'b0110 : (s == 1) ? 4'b0101 : 4'b0011,
                          (s == 0) ? 4'hA : (s == 1) ? 4'hB : 4'hC, 1, "b_scan");
        end
        for (int h = 1; h <= 2; h++)
            applyStimulus(1, 0, 1, 16'h0CBA, 4'b0111, 1, 4'b0101, 4'hB, 0, "b_hold");
        applyStimulus(1, 0, 0, 16'h0CBA, 4'b0111, 2, 4'b0011, 4'hC, 1, "b_release");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
